cycle_timer: RTL and testbench

CYCLE_TIMER -- requirements
Module: cycle_timer

---
 rtl/cycle_timer.sv | 169 ++++++++++++++++
 tb/tb_cycle_timer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/cycle_timer.sv
// ----------------------------------------------------------------------------
// cycle_timer
//
// Phase timer for the washing-machine controller. When the controlling FSM
// requests a run, the timer loads a duration of timer_period steps, each
// SECONDS_PER_STEP seconds long. It then counts it down once per second,
// where one second is TICKS_PER_SEC clock cycles. The run can be paused,
// resumed and aborted. A level flag and a one-cycle strobe report that the
// phase has elapsed.
//
// Parameters
//   TICKS_PER_SEC     clk cycles per second
//   SECONDS_PER_STEP  seconds represented by one timer_period count
//
// Ports
//   clk                rising-edge clock
//   reset              synchronous active-high reset; highest priority
//   timer_reset        synchronous clear to IDLE from the FSM
//   timer_enable       run request; low pauses a running phase
//   timer_period[3:0]  phase duration in steps, sampled only at load
//   timer_done         level flag, high while in DONE
//   done_pulse         one-cycle strobe on entry to DONE
//   timer_running      high only while counting (RUN)
//   remaining_seconds  seconds left in the current phase, for display
//
// All outputs come straight from flops, so no input reaches an output
// combinationally.
// ----------------------------------------------------------------------------
module cycle_timer #(
  parameter int TICKS_PER_SEC    = 5,
  parameter int SECONDS_PER_STEP = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        timer_reset,
  input  logic        timer_enable,
  input  logic [3:0]  timer_period,
  output logic        timer_done,
  output logic        done_pulse,
  output logic        timer_running,
  output logic [15:0] remaining_seconds
);

  // The prescaler is at least one bit wide, so TICKS_PER_SEC = 1 still
  // elaborates. In that case it stays at 0 and every enabled cycle is a tick.
  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSED,
    ST_DONE
  } state_e;

  state_e         state_q,     state_d;
  logic [PW-1:0]  presc_q,     presc_d;
  logic [15:0]    remaining_q, remaining_d;
  logic           done_q,      done_d;
  logic           pulse_q,     pulse_d;
  logic           running_q,   running_d;

  // The product is formed at 32 bits and then truncated to 16 bits. A
  // product that truncates to zero behaves like a zero-length phase.
  logic [31:0] duration_full;
  logic [15:0] duration;

  always_comb begin
    duration_full = 32'(timer_period) * 32'(SECONDS_PER_STEP);
    duration      = duration_full[15:0];
  end

  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    state_d     = state_q;
    presc_d     = presc_q;
    remaining_d = remaining_q;
    done_d      = done_q;
    pulse_d     = 1'b0;
    running_d   = running_q;

    unique case (state_q)
      ST_IDLE: begin
        if (timer_enable) begin
          presc_d = '0;
          if (duration == 16'd0) begin
            state_d     = ST_DONE;
            remaining_d = 16'd0;
            done_d      = 1'b1;
            pulse_d     = 1'b1;
          end else begin
            state_d     = ST_RUN;
            remaining_d = duration;
            running_d   = 1'b1;
          end
        end
      end

      // RUN and PAUSED share one counting rule. Every cycle sampled with
      // enable high advances the prescaler, including the cycle that resumes
      // from PAUSED. A pause therefore delays completion by exactly the
      // number of cycles sampled with enable low.
      ST_RUN, ST_PAUSED: begin
        if (!timer_enable) begin
          state_d   = ST_PAUSED;
          running_d = 1'b0;
        end else begin
          state_d   = ST_RUN;
          running_d = 1'b1;
          if (presc_q == PRESC_LAST) begin
            presc_d     = '0;
            remaining_d = remaining_q - 16'd1;
            if (remaining_q == 16'd1) begin
              state_d   = ST_DONE;
              running_d = 1'b0;
              done_d    = 1'b1;
              pulse_d   = 1'b1;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
      end

      // DONE holds until the timer is cleared. The done flag stays high and
      // remaining_seconds stays at zero.
      ST_DONE: ;

      default: state_d = ST_IDLE;
    endcase

    // An abort from the FSM overrides everything above, including enable.
    if (timer_reset) begin
      state_d     = ST_IDLE;
      presc_d     = '0;
      remaining_d = 16'd0;
      done_d      = 1'b0;
      pulse_d     = 1'b0;
      running_d   = 1'b0;
    end
  end

  // NOTE: state is updated only with non-blocking assignments, so every flop
  // samples the values from before the edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      presc_q     <= '0;
      remaining_q <= 16'd0;
      done_q      <= 1'b0;
      pulse_q     <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
      pulse_q     <= pulse_d;
      running_q   <= running_d;
    end
  end

  assign timer_done        = done_q;
  assign done_pulse        = pulse_q;
  assign timer_running     = running_q;
  assign remaining_seconds = remaining_q;

endmodule

// File: tb/tb_cycle_timer.sv
// ----------------------------------------------------------------------------
// tb_cycle_timer
//
// Self-checking bench for cycle_timer with TICKS_PER_SEC=2, SECONDS_PER_STEP=1.
// The reference model tracks a phase as "enabled cycles elapsed" against a
// total of duration*TICKS_PER_SEC. Remaining seconds are derived by division.
// All four outputs are compared after every clock edge. Directed scenarios
// come first, followed by a randomized soak.
// ----------------------------------------------------------------------------
module tb_cycle_timer;

  localparam int TPS = 2;
  localparam int SPS = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        timer_reset;
  logic        timer_enable;
  logic [3:0]  timer_period;
  logic        timer_done;
  logic        done_pulse;
  logic        timer_running;
  logic [15:0] remaining_seconds;

  always #5 clk = ~clk;

  cycle_timer #(
    .TICKS_PER_SEC    (TPS),
    .SECONDS_PER_STEP (SPS)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .timer_reset       (timer_reset),
    .timer_enable      (timer_enable),
    .timer_period      (timer_period),
    .timer_done        (timer_done),
    .done_pulse        (done_pulse),
    .timer_running     (timer_running),
    .remaining_seconds (remaining_seconds)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  bit m_active;    // a phase is loaded and not yet complete
  bit m_done;
  bit m_pulse;
  bit m_running;
  int m_dur;       // phase length in seconds
  int m_elapsed;   // enabled cycles counted since the load

  function automatic int m_remaining();
    if (m_active) return m_dur - (m_elapsed / TPS);
    return 0;
  endfunction

  task automatic model_edge();
    m_pulse = 1'b0;
    if (reset || timer_reset) begin
      m_active  = 1'b0;
      m_done    = 1'b0;
      m_running = 1'b0;
    end else if (m_done) begin
      // DONE holds until it is cleared.
    end else if (m_active) begin
      if (timer_enable) begin
        m_elapsed++;
        m_running = 1'b1;
        if (m_elapsed == m_dur * TPS) begin
          m_active  = 1'b0;
          m_done    = 1'b1;
          m_pulse   = 1'b1;
          m_running = 1'b0;
        end
      end else begin
        m_running = 1'b0;
      end
    end else if (timer_enable) begin
      m_dur     = (int'(timer_period) * SPS) & 16'hFFFF;
      m_elapsed = 0;
      if (m_dur == 0) begin
        m_done  = 1'b1;
        m_pulse = 1'b1;
      end else begin
        m_active  = 1'b1;
        m_running = 1'b1;
      end
    end
  endtask

  // One clock edge: update the model from the sampled inputs, then compare
  // the outputs 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("timer_done",    32'(timer_done),        32'(m_done));
    check("done_pulse",    32'(done_pulse),        32'(m_pulse));
    check("timer_running", 32'(timer_running),     32'(m_running));
    check("remaining",     32'(remaining_seconds), 32'(m_remaining()));
  endtask

  int cnt;

  initial begin
    reset        = 1'b1;
    timer_reset  = 1'b0;
    timer_enable = 1'b0;
    timer_period = 4'd0;
    m_active = 0; m_done = 0; m_pulse = 0; m_running = 0;
    m_dur = 0; m_elapsed = 0;
    tick();
    tick();
    check("reset_remaining", 32'(remaining_seconds), 32'd0);
    check("reset_done",      32'(timer_done),        32'd0);
    reset = 1'b0;
    tick();

    // Basic run: period 3, then a period change after the load edge.
    timer_period = 4'd3;
    timer_enable = 1'b1;
    tick();
    check("basic_load_rem", 32'(remaining_seconds), 32'd3);
    timer_period = 4'd9;
    cnt = 0;
    while (!timer_done && cnt < 50) begin tick(); cnt++; end
    check("basic_done_latency", 32'(cnt), 32'd6);
    check("basic_pulse_first", 32'(done_pulse), 32'd1);
    tick();
    check("basic_pulse_second", 32'(done_pulse), 32'd0);
    check("done_holds_rem", 32'(remaining_seconds), 32'd0);

    // Pause for 5 cycles at remaining = 2.
    timer_reset = 1'b1; tick();
    timer_reset = 1'b0; timer_enable = 1'b0; tick();
    timer_period = 4'd4;
    timer_enable = 1'b1;
    tick();
    cnt = 0;
    while (remaining_seconds != 16'd2 && cnt < 50) begin tick(); cnt++; end
    timer_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(); cnt++;
      check("pause_rem", 32'(remaining_seconds), 32'd2);
      check("pause_running", 32'(timer_running), 32'd0);
    end
    timer_enable = 1'b1;
    while (!timer_done && cnt < 100) begin tick(); cnt++; end
    check("pause_done_latency", 32'(cnt), 32'd13);

    // Zero period.
    timer_reset = 1'b1; tick();
    timer_reset = 1'b0;
    timer_period = 4'd0;
    tick();
    check("zero_done",    32'(timer_done),    32'd1);
    check("zero_pulse",   32'(done_pulse),    32'd1);
    check("zero_running", 32'(timer_running), 32'd0);
    tick();
    check("zero_pulse_drop", 32'(done_pulse), 32'd0);

    // Abort mid-run, with an immediate reload.
    timer_reset = 1'b1; tick();
    timer_reset = 1'b0;
    timer_period = 4'd5;
    tick();
    tick(); tick(); tick();
    timer_reset = 1'b1; tick();
    check("abort_running", 32'(timer_running), 32'd0);
    check("abort_rem",     32'(remaining_seconds), 32'd0);
    timer_reset = 1'b0;
    tick();
    check("reload_rem", 32'(remaining_seconds), 32'd5);

    // Reset in DONE.
    timer_reset = 1'b1; tick();
    timer_reset = 1'b0; timer_period = 4'd1;
    cnt = 0;
    while (!timer_done && cnt < 20) begin tick(); cnt++; end
    check("pre_reset_done", 32'(timer_done), 32'd1);
    reset = 1'b1; tick();
    check("reset_in_done", 32'(timer_done), 32'd0);
    check("reset_in_done_rem", 32'(remaining_seconds), 32'd0);
    reset = 1'b0; timer_enable = 1'b0; tick();

    // Randomized soak.
    for (int i = 0; i < 4000; i++) begin
      reset        = ($urandom_range(99) < 2);
      timer_reset  = ($urandom_range(99) < 3);
      timer_enable = ($urandom_range(99) < 80);
      if ($urandom_range(99) < 30) timer_period = 4'($urandom_range(15));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
